alu_seq_hs: RTL and testbench



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_core.sv | 55 +++++
 rtl/alu_seq_hs.sv | 147 ++++++++++++++
 tb/tb_alu_seq_hs.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the handshaked sequential ALU: opcodes, FSM encodings
// and the shift-amount width helper.
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  // Number of B bits used as shift amount; at least one so the slice is legal.
  function automatic int shamt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational W-bit ALU: arithmetic, logic and shifts with carry/borrow,
// signed overflow and unsupported-opcode flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int NB_OP = OP_W
) (
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [NB_OP-1:0] op,
  output logic [W-1:0]     res,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int SW = shamt_bits(W);

  logic [SW-1:0] sh_s;
  logic [W:0]    sum_s;
  logic [W:0]    diff_s;

  assign sh_s   = b[SW-1:0];
  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};

  // Opcode decode; the extra MSB of diff_s is the unsigned borrow.
  always_comb begin
    res   = {W{1'b0}};
    carry = 1'b0;
    ovf   = 1'b0;
    err   = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum_s[W-1:0];
        carry = sum_s[W];
        ovf   = (a[W-1] == b[W-1]) && (sum_s[W-1] != a[W-1]);
      end
      OP_SUB: begin
        res   = diff_s[W-1:0];
        carry = diff_s[W];
        ovf   = (a[W-1] != b[W-1]) && (diff_s[W-1] != a[W-1]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_SRL:  res = a >> sh_s;
      OP_SRA:  res = W'($signed(a) >>> sh_s);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_hs.sv
// Sequential ALU: collects A, B, OP over a valid/ready input stream, computes
// in one registered stage and holds the result on a valid/ready output.
module alu_seq_hs
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int NB_OP = OP_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] Z,
  output logic         carry,
  output logic         ovf,
  output logic         zero,
  output logic         err,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [2:0]       state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [NB_OP-1:0] op_q, op_d;
  logic [W-1:0]     z_q, z_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  logic [W-1:0]     core_res_s;
  logic             core_carry_s;
  logic             core_ovf_s;
  logic             core_err_s;

  alu_core #(.W(W), .NB_OP(NB_OP)) u_core (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .res   (core_res_s),
    .carry (core_carry_s),
    .ovf   (core_ovf_s),
    .err   (core_err_s)
  );

  assign in_ready = (state_q == S_A) || (state_q == S_B) || (state_q == S_OP);

  // Next-state and register-update logic for the capture/exec/output sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    z_d         = z_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_A: begin
        if (in_valid) begin
          a_d     = in_data;
          state_d = S_B;
        end else begin
          state_d = S_A;
        end
      end
      S_B: begin
        if (in_valid) begin
          b_d     = in_data;
          state_d = S_OP;
        end else begin
          state_d = S_B;
        end
      end
      S_OP: begin
        if (in_valid) begin
          op_d    = in_data[NB_OP-1:0];
          state_d = S_EXEC;
        end else begin
          state_d = S_OP;
        end
      end
      S_EXEC: begin
        z_d         = core_res_s;
        carry_d     = core_carry_s;
        ovf_d       = core_ovf_s;
        zero_d      = (core_res_s == {W{1'b0}});
        err_d       = core_err_s;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        // Result registers are left untouched after the transfer.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_A;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_A;
      end
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_A;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      op_q        <= {NB_OP{1'b0}};
      z_q         <= {W{1'b0}};
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      z_q         <= z_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Z         = z_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq_hs.sv
// Self-checking bench for alu_seq_hs (W=8): word-level reference model,
// per-cycle compare process, directed cases and randomized transactions.
module tb_alu_seq_hs;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] Z;
  logic       carry, ovf, zero, err, out_valid;
  logic       out_ready = 1'b0;

  alu_seq_hs #(.W(8), .NB_OP(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Z         (Z),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] z;
    logic       c;
    logic       v;
    logic       zr;
    logic       e;
  } res_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from plain integer arithmetic.
  function automatic res_t ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    res_t r;
    int ia, ib, sa, sb, t, k;
    ia = a; ib = b;
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    k  = ib % 8;
    r  = '0;
    t  = 0;
    case (op)
      6'd32: begin t = ia + ib; r.c = (t > 255); r.v = ((sa + sb) > 127) || ((sa + sb) < -128); end
      6'd34: begin t = ia - ib; r.c = (ia < ib); r.v = ((sa - sb) > 127) || ((sa - sb) < -128); end
      6'd36: t = ia & ib;
      6'd37: t = ia | ib;
      6'd38: t = ia ^ ib;
      6'd39: t = ~(ia | ib);
      6'd2:  t = ia >> k;
      6'd3:  t = sa >>> k;
      default: begin t = 0; r.e = 1'b1; end
    endcase
    r.z  = t[7:0];
    r.zr = (r.z == 8'h00);
    return r;
  endfunction

  // Word-level model: count captured words, then one exec cycle, then hold.
  int         m_words = 0;
  logic       m_pend = 1'b0;
  logic       m_ov = 1'b0;
  logic [7:0] m_a = 8'h00, m_b = 8'h00;
  logic [5:0] m_op = 6'h00;
  res_t       m_res = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_words <= 0; m_pend <= 1'b0; m_ov <= 1'b0; m_res <= '0;
    end else if (m_pend) begin
      m_res <= ref_alu(m_a, m_b, m_op); m_pend <= 1'b0; m_ov <= 1'b1;
    end else if (m_ov) begin
      if (out_ready) m_ov <= 1'b0;
    end else if (in_valid) begin
      if (m_words == 0) begin m_a <= in_data; m_words <= 1; end
      else if (m_words == 1) begin m_b <= in_data; m_words <= 2; end
      else begin m_op <= in_data[5:0]; m_words <= 0; m_pend <= 1'b1; end
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("in_ready",  in_ready,  !(m_pend || m_ov));
      check("out_valid", out_valid, m_ov);
      check("Z",         Z,         m_res.z);
      check("carry",     carry,     m_res.c);
      check("ovf",       ovf,       m_res.v);
      check("zero",      zero,      m_res.zr);
      check("err",       err,       m_res.e);
    end
  end

  task automatic send_word(input logic [7:0] w);
    bit acc = 1'b0;
    int n = 0;
    in_data = w;
    in_valid = 1'b1;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_data = 8'($urandom);
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got no accept, expected accept within 40 cycles");
    end
  endtask

  task automatic collect(input int hold, input bit toggle, output res_t got);
    int n = 0;
    check("lat_pre", out_valid, 1'b0);
    @(posedge clk); #1;
    check("lat", out_valid, 1'b1);
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    got = {Z, carry, ovf, zero, err};
    for (int i = 0; i < hold; i++) begin
      if (toggle) begin in_valid = 1'b1; in_data = i[0] ? 8'hA5 : 8'h3C; end
      @(posedge clk); #1;
      check("hold_z", Z, m_res.z);
      check("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    if (toggle) begin in_valid = 1'b1; in_data = 8'h5A; end
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("post_out_valid", out_valid, 1'b0);
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opw,
                     input int hold, input bit toggle, output res_t got);
    send_word(a);
    send_word(b);
    send_word(opw);
    collect(hold, toggle, got);
  endtask

  task automatic expect_res(input string name, input res_t got, input res_t exp);
    check({name, "_z"},    got.z,  exp.z);
    check({name, "_c"},    got.c,  exp.c);
    check({name, "_v"},    got.v,  exp.v);
    check({name, "_zero"}, got.zr, exp.zr);
    check({name, "_err"},  got.e,  exp.e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    res_t got, pin;
    logic [7:0] ra, rb, ro;
    logic [5:0] ops [8] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd2, 6'd3};

    // Pin the reference model against hand-computed values.
    pin = ref_alu(8'hCC, 8'hF0, 6'h27); check("pin_nor", pin, {8'h03, 4'b0000});
    pin = ref_alu(8'h80, 8'h0B, 6'h03); check("pin_sra", pin, {8'hF0, 4'b0000});
    pin = ref_alu(8'h05, 8'h07, 6'h22); check("pin_sub", pin, {8'hFE, 4'b1000});

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_Z", Z, 8'h00);
    check("rst_flags", {carry, ovf, zero, err, out_valid}, 5'b00000);
    check("rst_in_ready", in_ready, 1'b1);
    chk_en = 1'b1;

    txn(8'hCC, 8'hF0, 8'h27, 2, 1'b0, got); expect_res("nor",   got, {8'h03, 4'b0000});
    txn(8'h7F, 8'h01, 8'h20, 0, 1'b0, got); expect_res("add_v", got, {8'h80, 4'b0100});
    txn(8'hFF, 8'h01, 8'h20, 1, 1'b0, got); expect_res("add_c", got, {8'h00, 4'b1010});
    txn(8'h05, 8'h07, 8'h22, 0, 1'b0, got); expect_res("sub_b", got, {8'hFE, 4'b1000});
    txn(8'h80, 8'h0B, 8'h03, 0, 1'b0, got); expect_res("sra",   got, {8'hF0, 4'b0000});
    txn(8'h80, 8'h0B, 8'hC2, 0, 1'b0, got); expect_res("srl",   got, {8'h10, 4'b0000});

    // Backpressure with in_valid toggling, then the next word must be A.
    txn(8'h12, 8'h34, 8'h26, 5, 1'b1, got); expect_res("bp_xor", got, {8'h26, 4'b0000});
    txn(8'h0C, 8'h0A, 8'h25, 0, 1'b0, got); expect_res("bp_next", got, {8'h0E, 4'b0000});

    txn(8'h55, 8'hAA, 8'h3F, 1, 1'b0, got); expect_res("bad_op", got, {8'h00, 4'b0011});
    txn(8'hCC, 8'hF0, 8'h27, 0, 1'b0, got); expect_res("err_clr", got, {8'h03, 4'b0000});

    // Asynchronous reset mid-cycle after A and B were captured.
    send_word(8'hAB);
    send_word(8'hCD);
    #3;
    reset = 1'b1;
    #1;
    check("async_Z", Z, 8'h00);
    check("async_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    txn(8'h0F, 8'hF0, 8'h24, 0, 1'b0, got); expect_res("and_rst", got, {8'h00, 4'b0010});

    for (int t = 0; t < 150; t++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = ($urandom_range(0, 9) == 0) ? 8'($urandom) : {2'($urandom), ops[$urandom_range(0, 7)]};
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      txn(ra, rb, ro, $urandom_range(0, 3), 1'($urandom), got);
      expect_res("rand", got, ref_alu(ra, rb, ro[5:0]));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
